request_unit: RTL and testbench

//  Consumes control-unit memory outputs (dread, dwrite) and sequences core bus requests:

---
 rtl/request_unit_if.sv | 27 ++
 rtl/request_unit.sv | 114 +++++++++++
 tb/tb_request_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/request_unit_if.sv
// Bus bundle between the request unit, control unit, datapath PC and memory controller.
// The master modport is the request unit's view; slave is the surrounding system.
interface request_unit_if;
   logic       ihit;
   logic       dhit;
   logic       dread;
   logic [1:0] dwrite;
   logic [1:0] daddr_lo;
   logic       halt;
   logic       imemREN;
   logic       dmemREN;
   logic       dmemWEN;
   logic [3:0] dmem_strb;
   logic       pc_en;
   logic       misalign;
   logic       timeout;

   modport master (
      input  ihit, dhit, dread, dwrite, daddr_lo, halt,
      output imemREN, dmemREN, dmemWEN, dmem_strb, pc_en, misalign, timeout
   );

   modport slave (
      output ihit, dhit, dread, dwrite, daddr_lo, halt,
      input  imemREN, dmemREN, dmemWEN, dmem_strb, pc_en, misalign, timeout
   );
endinterface

// File: rtl/request_unit.sv
// Sequences instruction fetch then an optional data access per instruction, holding the
// data request until dhit or timeout and stalling the PC until the instruction completes.
module request_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input logic           CLK,
   input logic           RST,
   request_unit_if.master bus
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DATA   = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] count;

   logic       store;
   logic       access;
   logic       misaligned;
   logic [3:0] strb_next;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      store      = (bus.dwrite != 2'b00);
      access     = store | bus.dread;
      misaligned = 1'b0;
      strb_next  = 4'b0000;
      unique case (bus.dwrite)
         2'b01: strb_next = 4'b0001 << bus.daddr_lo;
         2'b10: begin
            strb_next  = 4'b0011 << {bus.daddr_lo[1], 1'b0};
            misaligned = bus.daddr_lo[0];
         end
         2'b11: begin
            strb_next  = 4'b1111;
            misaligned = (bus.daddr_lo != 2'b00);
         end
         default: strb_next = 4'b0000;
      endcase
   end

   // Fetch and PC advance are combinational so a single-cycle memory gives one instr/cycle.
   assign bus.imemREN = (state == FETCH) && !bus.halt;
   assign bus.pc_en   = ((state == FETCH) && !bus.halt && bus.ihit && !access) ||
                        ((state == DATA) && bus.dhit);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state         <= FETCH;
         count         <= '0;
         bus.dmemREN   <= 1'b0;
         bus.dmemWEN   <= 1'b0;
         bus.dmem_strb <= 4'b0000;
         bus.misalign  <= 1'b0;
         bus.timeout   <= 1'b0;
      end else begin
         unique case (state)
            FETCH: begin
               if (bus.halt) begin
                  state <= HALTED;
               end else if (bus.ihit && access) begin
                  if (misaligned) begin
                     bus.misalign <= 1'b1;
                     state        <= HALTED;
                  end else begin
                     // A store takes precedence over a simultaneous load request.
                     bus.dmemWEN   <= store;
                     bus.dmemREN   <= bus.dread & ~store;
                     bus.dmem_strb <= strb_next;
                     count         <= '0;
                     state         <= DATA;
                  end
               end
            end
            DATA: begin
               if (bus.dhit) begin
                  bus.dmemREN   <= 1'b0;
                  bus.dmemWEN   <= 1'b0;
                  bus.dmem_strb <= 4'b0000;
                  state         <= FETCH;
               end else if (count == LAST_CNT) begin
                  bus.timeout   <= 1'b1;
                  bus.dmemREN   <= 1'b0;
                  bus.dmemWEN   <= 1'b0;
                  bus.dmem_strb <= 4'b0000;
                  state         <= HALTED;
               end else begin
                  count <= count + 1'b1;
               end
            end
            HALTED: begin
               bus.dmemREN   <= 1'b0;
               bus.dmemWEN   <= 1'b0;
               bus.dmem_strb <= 4'b0000;
            end
            default: begin
               bus.dmemREN   <= 1'b0;
               bus.dmemWEN   <= 1'b0;
               bus.dmem_strb <= 4'b0000;
               state         <= HALTED;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit: fetch-only, load, store strobes, timeout, misalignment,
// halt and asynchronous reset, with a short timeout so the abort path is reachable.
module tb_request_unit;

   logic CLK;
   logic RST;
   int   n_checks;
   int   n_fail;

   request_unit_if bus ();

   request_unit #(
      .TIMEOUT_CYCLES(4),
      .CNT_W         (8)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      bus.ihit     = 1'b0;
      bus.dhit     = 1'b0;
      bus.dread    = 1'b0;
      bus.dwrite   = 2'b00;
      bus.daddr_lo = 2'b00;
      bus.halt     = 1'b0;
   endtask

   // Issue one store from FETCH and complete it with a dhit in the first data cycle.
   task automatic do_store(input string tag, input logic [1:0] size, input logic [1:0] addr,
                           input logic rd, input logic [3:0] exp_strb);
      bus.ihit     = 1'b1;
      bus.dwrite   = size;
      bus.daddr_lo = addr;
      bus.dread    = rd;
      #1;
      check({tag, "_pc_en_ihit"}, {3'b0, bus.pc_en}, 4'b0000);
      cyc();
      idle_inputs();
      #1;
      check({tag, "_wen"},  {3'b0, bus.dmemWEN}, 4'b0001);
      check({tag, "_ren"},  {3'b0, bus.dmemREN}, 4'b0000);
      check({tag, "_strb"}, bus.dmem_strb, exp_strb);
      bus.dhit = 1'b1;
      #1;
      check({tag, "_pc_en_dhit"}, {3'b0, bus.pc_en}, 4'b0001);
      cyc();
      bus.dhit = 1'b0;
      #1;
      check({tag, "_wen_clr"},  {3'b0, bus.dmemWEN}, 4'b0000);
      check({tag, "_strb_clr"}, bus.dmem_strb, 4'b0000);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      idle_inputs();
      RST = 1'b1;
      #1;
      check("rst_ren",      {3'b0, bus.dmemREN},  4'b0000);
      check("rst_wen",      {3'b0, bus.dmemWEN},  4'b0000);
      check("rst_strb",     bus.dmem_strb,        4'b0000);
      check("rst_misalign", {3'b0, bus.misalign}, 4'b0000);
      check("rst_timeout",  {3'b0, bus.timeout},  4'b0000);
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      #1;
      check("rel_imem", {3'b0, bus.imemREN}, 4'b0001);

      // ALU instruction: PC advances in the ihit cycle, no data request.
      cyc();
      bus.ihit = 1'b1;
      #1;
      check("alu_pc_en", {3'b0, bus.pc_en},   4'b0001);
      check("alu_imem",  {3'b0, bus.imemREN}, 4'b0001);
      cyc();
      bus.ihit = 1'b0;
      #1;
      check("alu_ren", {3'b0, bus.dmemREN}, 4'b0000);
      check("alu_wen", {3'b0, bus.dmemWEN}, 4'b0000);
      check("alu_idle_pc_en", {3'b0, bus.pc_en}, 4'b0000);

      // Load at an unaligned address (loads are never checked), dhit on third data cycle.
      bus.ihit     = 1'b1;
      bus.dread    = 1'b1;
      bus.daddr_lo = 2'b11;
      #1;
      check("ld_pc_en_ihit", {3'b0, bus.pc_en}, 4'b0000);
      cyc();
      idle_inputs();
      #1;
      check("ld_ren",  {3'b0, bus.dmemREN}, 4'b0001);
      check("ld_imem", {3'b0, bus.imemREN}, 4'b0000);
      check("ld_strb", bus.dmem_strb,       4'b0000);
      check("ld_misalign", {3'b0, bus.misalign}, 4'b0000);
      bus.ihit = 1'b1;
      #1;
      check("ld_ihit_ignored", {3'b0, bus.pc_en}, 4'b0000);
      bus.ihit = 1'b0;
      cyc();
      cyc();
      bus.dhit = 1'b1;
      #1;
      check("ld_pc_en_dhit", {3'b0, bus.pc_en},   4'b0001);
      check("ld_ren_held",   {3'b0, bus.dmemREN}, 4'b0001);
      cyc();
      bus.dhit = 1'b0;
      #1;
      check("ld_ren_clr",  {3'b0, bus.dmemREN}, 4'b0000);
      check("ld_imem_ret", {3'b0, bus.imemREN}, 4'b0001);

      // Stores: strobe derivation, and store winning over a simultaneous load.
      do_store("st_byte2", 2'b01, 2'd2, 1'b0, 4'b0100);
      do_store("st_half2", 2'b10, 2'd2, 1'b0, 4'b1100);
      do_store("st_word0", 2'b11, 2'd0, 1'b0, 4'b1111);
      do_store("st_byte3_rd", 2'b01, 2'd3, 1'b1, 4'b1000);
      do_store("st_half0", 2'b10, 2'd0, 1'b0, 4'b0011);

      // dhit on the last permitted cycle completes the access without timeout.
      bus.ihit  = 1'b1;
      bus.dread = 1'b1;
      cyc();
      idle_inputs();
      cyc();
      cyc();
      cyc();
      bus.dhit = 1'b1;
      #1;
      check("to_edge_pc_en", {3'b0, bus.pc_en}, 4'b0001);
      cyc();
      bus.dhit = 1'b0;
      #1;
      check("to_edge_timeout", {3'b0, bus.timeout}, 4'b0000);
      check("to_edge_ren",     {3'b0, bus.dmemREN}, 4'b0000);
      check("to_edge_imem",    {3'b0, bus.imemREN}, 4'b0001);

      // No dhit: request held exactly four cycles, then aborted into HALTED.
      bus.ihit  = 1'b1;
      bus.dread = 1'b1;
      cyc();
      idle_inputs();
      #1;
      check("to_ren_c1", {3'b0, bus.dmemREN}, 4'b0001);
      cyc();
      check("to_ren_c2", {3'b0, bus.dmemREN}, 4'b0001);
      cyc();
      check("to_ren_c3", {3'b0, bus.dmemREN}, 4'b0001);
      cyc();
      check("to_ren_c4",  {3'b0, bus.dmemREN}, 4'b0001);
      check("to_flag_c4", {3'b0, bus.timeout}, 4'b0000);
      cyc();
      check("to_flag",     {3'b0, bus.timeout}, 4'b0001);
      check("to_ren_drop", {3'b0, bus.dmemREN}, 4'b0000);
      check("to_imem",     {3'b0, bus.imemREN}, 4'b0000);
      bus.dhit = 1'b1;
      bus.ihit = 1'b1;
      #1;
      check("to_halted_pc_en", {3'b0, bus.pc_en}, 4'b0000);
      idle_inputs();
      RST = 1'b1;
      #1;
      check("to_rst_clear", {3'b0, bus.timeout}, 4'b0000);
      cyc();
      RST = 1'b0;
      cyc();

      // Misaligned word store: sticky flag, halted, no write issued.
      bus.ihit     = 1'b1;
      bus.dwrite   = 2'b11;
      bus.daddr_lo = 2'b01;
      #1;
      check("mis_pc_en", {3'b0, bus.pc_en}, 4'b0000);
      cyc();
      idle_inputs();
      #1;
      check("mis_flag", {3'b0, bus.misalign}, 4'b0001);
      check("mis_wen",  {3'b0, bus.dmemWEN},  4'b0000);
      check("mis_imem", {3'b0, bus.imemREN},  4'b0000);
      cyc();
      check("mis_sticky", {3'b0, bus.misalign}, 4'b0001);
      RST = 1'b1;
      #1;
      check("mis_rst_clear", {3'b0, bus.misalign}, 4'b0000);
      cyc();
      RST = 1'b0;
      cyc();

      // Misaligned half store (odd address) also halts.
      bus.ihit     = 1'b1;
      bus.dwrite   = 2'b10;
      bus.daddr_lo = 2'b11;
      cyc();
      idle_inputs();
      #1;
      check("mis_half_flag", {3'b0, bus.misalign}, 4'b0001);
      RST = 1'b1;
      cyc();
      RST = 1'b0;
      cyc();

      // halt in FETCH drops the fetch request combinationally and parks the unit.
      bus.halt = 1'b1;
      bus.ihit = 1'b1;
      #1;
      check("halt_imem",  {3'b0, bus.imemREN}, 4'b0000);
      check("halt_pc_en", {3'b0, bus.pc_en},   4'b0000);
      cyc();
      bus.halt = 1'b0;
      #1;
      check("halted_imem",  {3'b0, bus.imemREN}, 4'b0000);
      check("halted_pc_en", {3'b0, bus.pc_en},   4'b0000);
      idle_inputs();
      RST = 1'b1;
      cyc();
      RST = 1'b0;
      cyc();

      // Reset pulse in the middle of a data request clears it without a clock edge.
      bus.ihit  = 1'b1;
      bus.dread = 1'b1;
      cyc();
      idle_inputs();
      #1;
      check("arst_ren_before", {3'b0, bus.dmemREN}, 4'b0001);
      #2;
      RST = 1'b1;
      #1;
      check("arst_ren_async", {3'b0, bus.dmemREN}, 4'b0000);
      check("arst_imem",      {3'b0, bus.imemREN}, 4'b0001);
      cyc();
      RST = 1'b0;
      bus.ihit = 1'b1;
      #1;
      check("arst_fetch_pc_en", {3'b0, bus.pc_en}, 4'b0001);
      cyc();
      idle_inputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
